// File: rtl/mprj_io_cfg_loader_pkg.sv
// Shared constants for the pad-configuration loader: chain geometry, FSM encoding, pad modes.
// Pure declarations; no logic, latency or flow control.
package mprj_io_cfg_loader_pkg;

    localparam int NUM_IO_DEF  = 38;
    localparam int CFG_W_DEF   = 13;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Pad mode words used by housekeeping reset defaults
    localparam logic [12:0] MGMT_STD_INPUT_NOPULL   = 13'h0403;
    localparam logic [12:0] MGMT_STD_INPUT_PULLDOWN = 13'h0c01;
    localparam logic [12:0] MGMT_STD_INPUT_PULLUP   = 13'h0801;
    localparam logic [12:0] MGMT_STD_OUTPUT         = 13'h1809;
    localparam logic [12:0] MGMT_STD_BIDIRECTIONAL  = 13'h1801;
    localparam logic [12:0] MGMT_STD_ANALOG         = 13'h000b;
    localparam logic [12:0] USER_STD_INPUT_NOPULL   = 13'h0402;
    localparam logic [12:0] USER_STD_OUTPUT         = 13'h1808;
    localparam logic [12:0] USER_STD_BIDIRECTIONAL  = 13'h1800;

endpackage

// File: rtl/mprj_io_cfg_loader_sclk_gen.sv
// Phase timer: phase_done pulses on the last of CLK_DIV enabled cycles, then restarts.
// Counter holds at zero whenever en is low, so every phase starts from a clean count.
module cfg_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_done
);

    logic [7:0] phase_cnt;

    assign phase_done = en && (phase_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || phase_done) begin
            phase_cnt <= 8'd0;
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Serialises NUM_IO pad config words (highest pad first, MSB first) onto the pad chain, then latches.
// Full load takes NUM_IO*(2+2*CFG_W*CLK_DIV)+CLK_DIV+1 cycles; start is ignored while busy.
module mprj_io_cfg_loader
    import mprj_io_cfg_loader_pkg::*;
#(
    parameter int NUM_IO  = NUM_IO_DEF,
    parameter int CFG_W   = CFG_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic             clk_osc,
    input  logic             FPGA_rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [5:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             serial_clock,
    output logic             serial_data_out,
    output logic             serial_load,
    output logic             serial_resetn
);

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       pad_idx;
    logic [3:0]       bit_cnt;
    logic [CFG_W-1:0] shreg;
    logic             phase_en;
    logic             phase_done;

    assign phase_en = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI) || (state == ST_LOAD);

    cfg_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk_osc),
        .rst        (FPGA_rst),
        .en         (phase_en),
        .phase_done (phase_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_LATCH;
            ST_LATCH:    state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_done) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    if (bit_cnt != 4'd0)      state_nxt = ST_SHIFT_LO;
                    else if (pad_idx != 6'd0) state_nxt = ST_FETCH;
                    else                      state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:     if (phase_done) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_osc) begin
        if (FPGA_rst) begin
            state         <= ST_IDLE;
            pad_idx       <= 6'd0;
            bit_cnt       <= 4'd0;
            shreg         <= '0;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
        end else begin
            state         <= state_nxt;
            serial_resetn <= 1'b1;
            // Pad-facing strobes are registered from next state so they cannot glitch
            serial_clock  <= (state_nxt == ST_SHIFT_HI);
            serial_load   <= (state_nxt == ST_LOAD);
            case (state)
                ST_IDLE: begin
                    if (start) pad_idx <= 6'(NUM_IO - 1);
                end
                ST_LATCH: begin
                    shreg   <= cfg_data;
                    bit_cnt <= 4'(CFG_W - 1);
                end
                ST_SHIFT_HI: begin
                    if (phase_done) begin
                        if (bit_cnt != 4'd0) begin
                            shreg   <= {shreg[CFG_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt - 4'd1;
                        end else if (pad_idx != 6'd0) begin
                            pad_idx <= pad_idx - 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign cfg_addr = pad_idx;
    // The array word is only valid in LATCH, so the first bit bypasses the shift register there
    assign serial_data_out = (state == ST_LATCH) ? cfg_data[CFG_W-1] : shreg[CFG_W-1];

endmodule
